// File: rtl/sli_pkg.sv
// Shared constants, FSM state type and elaboration helpers for the
// synchronous delay line.
package sli_pkg;

  localparam int unsigned DEF_WIDTH     = 3;
  localparam int unsigned DEF_MAX_DEPTH = 16;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } fill_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/delay_ram.sv
// Delay-line storage: one synchronous write port and one asynchronous read
// port, no reset, so it maps onto distributed RAM.
module delay_ram
  import sli_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_MAX_DEPTH,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_delay_line.sv
// Programmable delay for a bundle of 1-bit channels: circular buffer with a
// wrapping write pointer, clamped delay select, fill tracking and output register.
module sync_delay_line
  import sli_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      MAX_DEPTH = DEF_MAX_DEPTH,
  parameter int unsigned      DEPTH_W   = 9,
  parameter logic [WIDTH-1:0] FILL_VAL  = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [WIDTH-1:0]   din,
  input  logic [DEPTH_W-1:0] delay_sel,
  input  logic               load,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
  output logic [DEPTH_W-1:0] cur_delay
);

  localparam int unsigned        PTR_W    = clog2(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] MAX_L    = DEPTH_W'(MAX_DEPTH);
  localparam logic [DEPTH_W-1:0] ONE_L    = DEPTH_W'(1);
  localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(MAX_DEPTH - 1);
  localparam logic [PTR_W-1:0]   PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_W-1:0] fill_cnt_q, fill_cnt_d;
  logic [DEPTH_W-1:0] cur_delay_q, cur_delay_d;
  fill_state_e        state_q, state_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  logic [DEPTH_W-1:0] sel_clamp_s;
  logic [DEPTH_W-1:0] eff_delay_s;
  logic [DEPTH_W-1:0] lag_s;
  logic [DEPTH_W-1:0] ptr_ext_s;
  logic [DEPTH_W-1:0] rd_wide_s;
  logic [DEPTH_W-1:0] cnt_base_s;
  logic [PTR_W-1:0]   rd_addr_s;
  logic [WIDTH-1:0]   rd_data_s;

  delay_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DEPTH),
    .AW    (PTR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (en),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_addr_s),
    .rdata_o (rd_data_s)
  );

  // Clamp the requested delay into 1..MAX_DEPTH and pick the delay for this edge.
  always_comb begin
    if (delay_sel == '0) begin
      sel_clamp_s = ONE_L;
    end else if (delay_sel > MAX_L) begin
      sel_clamp_s = MAX_L;
    end else begin
      sel_clamp_s = delay_sel;
    end
    if (load) begin
      eff_delay_s = sel_clamp_s;
    end else begin
      eff_delay_s = cur_delay_q;
    end
  end

  // Read address wr_ptr-(L-1) folded explicitly into 0..MAX_DEPTH-1; the
  // wrapped sum stays below MAX_DEPTH so no intermediate overflow matters.
  always_comb begin
    lag_s     = eff_delay_s - ONE_L;
    ptr_ext_s = DEPTH_W'(wr_ptr_q);
    if (ptr_ext_s >= lag_s) begin
      rd_wide_s = ptr_ext_s - lag_s;
    end else begin
      rd_wide_s = ptr_ext_s + (MAX_L - lag_s);
    end
    rd_addr_s = rd_wide_s[PTR_W-1:0];
  end

  // Next-state: pointer, saturating fill counter, fill FSM and output data.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    cur_delay_d = cur_delay_q;
    state_d     = state_q;
    dout_d      = dout_q;
    cnt_base_s  = fill_cnt_q;

    if (load) begin
      cur_delay_d = sel_clamp_s;
      cnt_base_s  = '0;
    end else begin
      cur_delay_d = cur_delay_q;
    end

    if (en) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_ONE;
      if (cnt_base_s >= eff_delay_s) begin
        fill_cnt_d = eff_delay_s;
      end else begin
        fill_cnt_d = cnt_base_s + ONE_L;
      end
    end else begin
      wr_ptr_d   = wr_ptr_q;
      fill_cnt_d = cnt_base_s;
    end

    if (en || load) begin
      case (fill_cnt_d == eff_delay_s)
        1'b1:    state_d = ST_RUN;
        1'b0:    state_d = ST_FILL;
        default: state_d = ST_FILL;
      endcase
      if (state_d == ST_RUN) begin
        // Delay 1 reads the slot being written this edge, so take din directly.
        dout_d = (eff_delay_s == ONE_L) ? din : rd_data_s;
      end else begin
        dout_d = FILL_VAL;
      end
    end else begin
      state_d = state_q;
      dout_d  = dout_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      cur_delay_q <= MAX_L;
      state_q     <= ST_FILL;
      dout_q      <= FILL_VAL;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      cur_delay_q <= cur_delay_d;
      state_q     <= state_d;
      dout_q      <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == ST_RUN);
  assign cur_delay  = cur_delay_q;

endmodule

// File: tb/tb_sync_delay_line.sv
// Randomized scoreboard bench for sync_delay_line: two instances (depth 16 and
// depth 12 with a nonzero fill value) against a sample-history reference model.
module tb_sync_delay_line;

  typedef struct {
    logic [2:0] d;
    logic       v;
    int         cd;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [2:0] din;
  logic [8:0] delay_sel;
  logic       load;
  logic [2:0] dout_a, dout_b;
  logic       valid_a, valid_b;
  logic [8:0] cd_a, cd_b;

  int checks = 0;
  int errors = 0;

  exp_t       sbq0[$];
  exp_t       sbq1[$];
  logic [2:0] hist[$];
  int         maxd[2];
  logic [2:0] fillv[2];
  int         lcur[2];
  int         ns[2];
  logic [2:0] ed[2];
  logic       ev[2];

  sync_delay_line #(.WIDTH(3), .MAX_DEPTH(16), .DEPTH_W(9), .FILL_VAL(3'b000)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .delay_sel(delay_sel), .load(load),
    .dout(dout_a), .dout_valid(valid_a), .cur_delay(cd_a)
  );

  sync_delay_line #(.WIDTH(3), .MAX_DEPTH(12), .DEPTH_W(9), .FILL_VAL(3'b110)) dut12 (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din), .delay_sel(delay_sel), .load(load),
    .dout(dout_b), .dout_valid(valid_b), .cur_delay(cd_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampf(input int s, input int m);
    if (s == 0) return 1;
    if (s > m) return m;
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      lcur[i] = maxd[i];
      ns[i]   = 0;
      ev[i]   = 1'b0;
      ed[i]   = fillv[i];
    end
  endtask

  // Drive one edge's inputs and predict the outputs right after that edge.
  task automatic cycle(input bit e, input bit ld, input int sel, input logic [2:0] d);
    exp_t x;
    @(negedge clk);
    en = e; load = ld; delay_sel = 9'(sel); din = d;
    if (e) hist.push_back(d);
    for (int i = 0; i < 2; i++) begin
      if (ld) begin
        lcur[i] = clampf(sel, maxd[i]);
        ns[i]   = e ? 1 : 0;
      end else if (e) begin
        ns[i]++;
      end
      if (ld || e) begin
        ev[i] = (ns[i] >= lcur[i]);
        ed[i] = ev[i] ? hist[hist.size() - lcur[i]] : fillv[i];
      end
      x.d = ed[i]; x.v = ev[i]; x.cd = lcur[i];
      if (i == 0) sbq0.push_back(x);
      else        sbq1.push_back(x);
    end
  endtask

  task automatic reset_check(input string tag);
    chk({tag, " dout16"},  int'(dout_a),  0);
    chk({tag, " valid16"}, int'(valid_a), 0);
    chk({tag, " cd16"},    int'(cd_a),    16);
    chk({tag, " dout12"},  int'(dout_b),  6);
    chk({tag, " valid12"}, int'(valid_b), 0);
    chk({tag, " cd12"},    int'(cd_b),    12);
  endtask

  // Reset pulse strictly between two rising edges.
  task automatic reset_mid();
    @(posedge clk);
    #2;
    en = 1'b0; load = 1'b0; rst_n = 1'b0;
    #1;
    reset_check("midreset");
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  // Monitor: compare each predicted post-edge state shortly after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq0.size() > 0) begin
        e = sbq0.pop_front();
        chk("dut16 dout",  int'(dout_a),  int'(e.d));
        chk("dut16 valid", int'(valid_a), int'(e.v));
        chk("dut16 cur",   int'(cd_a),    e.cd);
      end
      if (sbq1.size() > 0) begin
        e = sbq1.pop_front();
        chk("dut12 dout",  int'(dout_b),  int'(e.d));
        chk("dut12 valid", int'(valid_b), int'(e.v));
        chk("dut12 cur",   int'(cd_b),    e.cd);
      end
    end
  end

  initial begin
    maxd[0] = 16; maxd[1] = 12;
    fillv[0] = 3'b000; fillv[1] = 3'b110;
    rst_n = 1'b1; en = 1'b0; load = 1'b0; din = 3'b000; delay_sel = 9'd0;
    #2 rst_n = 1'b0;
    #1 reset_check("reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single marker through delay 4.
    cycle(1'b1, 1'b1, 4, 3'b001);
    repeat (8) cycle(1'b1, 1'b0, 0, 3'b000);

    // Clamping: 0 -> 1, 40 -> max depth.
    cycle(1'b1, 1'b1, 0, 3'b101);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 0, 3'(k));
    cycle(1'b1, 1'b1, 40, 3'b011);
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 0, 3'(k + 3));

    // Delay 12 with an incrementing pattern across pointer wrap.
    cycle(1'b1, 1'b1, 12, 3'b000);
    for (int k = 1; k < 50; k++) cycle(1'b1, 1'b0, 0, 3'(k));

    // Enable gaps while running at delay 3.
    cycle(1'b1, 1'b1, 3, 3'b111);
    for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 0, 3'(k));
    for (int k = 0; k < 12; k++) cycle((k % 4 == 0) || (k % 4 == 3), 1'b0, 0, 3'(k + 2));

    // Shrink delay from 8 to 2 while running.
    cycle(1'b1, 1'b1, 8, 3'b010);
    for (int k = 0; k < 12; k++) cycle(1'b1, 1'b0, 0, 3'(k * 3));
    cycle(1'b1, 1'b1, 2, 3'b100);
    for (int k = 0; k < 6; k++) cycle(1'b1, 1'b0, 0, 3'(k + 1));

    // Back-to-back loads, same-delay reload, load with enable low.
    cycle(1'b1, 1'b1, 3, 3'b001);
    cycle(1'b1, 1'b1, 3, 3'b010);
    cycle(1'b1, 1'b1, 5, 3'b011);
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 0, 3'(k));
    cycle(1'b1, 1'b1, 5, 3'b110);
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b0, 0, 3'(k + 4));
    cycle(1'b0, 1'b1, 1, 3'b111);
    cycle(1'b0, 1'b0, 0, 3'b000);
    for (int k = 0; k < 4; k++) cycle(1'b1, 1'b0, 0, 3'(k + 5));

    // Reset mid-run, then a fresh fill at max depth.
    reset_mid();
    for (int k = 0; k < 20; k++) cycle(1'b1, 1'b0, 0, 3'(k));

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset_mid();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
              int'($urandom_range(0, 40)), 3'($urandom_range(0, 7)));
      end
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("scoreboard drained", sbq0.size() + sbq1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
